div_timer_bank: RTL
===================

// Module: div_timer_bank
// PURPOSE
//  Parametrised successor of the fixed 16-bit divider. It holds one free-running system divider and
//  N_TIMERS independent programmable timer channels, each clocked from a selectable divider tap.
//  Each channel has modulo reload and an overflow interrupt, and the whole block is CPU-accessible
//  over the byte bus. It sits beside clock/reset generation and feeds the interrupt controller and
//  the APU frame sequencer (via div_tap).
// PARAMETERS
//  DIV_W      16       divider width, 8..24; CPU sees bits [DIV_W-1:DIV_W-8]
//  N_TIMERS   1        timer channels, 1..4
//  TAP0..TAP3 9,3,5,7  divider bit index chosen by ctrl.sel=0..3; each < DIV_W
//  APU_TAP    12       divider bit exported on div_tap
// PORTS
//  clk1       in   1           system clock; all state on rising edge
//  nreset     in   1           synchronous active-low reset
//  ce         in   1           divider advance enable (4 MHz tick); divider holds when 0
//  addr       in   4           register offset: 0=DIV, 4n+1=CNTn, 4n+2=MODn, 4n+3=CTLn
//  wdata      in   8           write data
//  wr         in   1           write strobe, one clk1 cycle per access
//  rd         in   1           read strobe
//  rdata      out  8           read data, combinational from addr while rd=1, else 0xFF
//  irq        out  N_TIMERS    per-channel overflow pulse, one clk1 cycle
//  div_tap    out  1           div[APU_TAP], glitch-free (direct flop output)
// BEHAVIOUR
//  Reset (nreset=0 at clk1 edge): div=0, CNT=0, MOD=0, CTL=0, irq=0, reload state IDLE.
//  Divider: div<=div+1 when ce=1, wrapping at 2^DIV_W. Any write to addr 0 clears all of div
//   (data ignored). A write wins over ce in the same cycle.
//  CTLn: bit2=en, bits1:0=sel. Bits 7:3 read as 1 and ignore writes.
//  Channel tick: t = en & div[TAP[sel]], registered as t_q. The counter increments when
//   t_q=1 & t=0 (falling edge). Consequences, intentional and required: a DIV clear, en 1->0,
//   or a sel change while the selected bit is 1 each produce one extra increment.
//  Overflow/reload FSM per channel. States: IDLE, DELAY, RELOAD.
//   - IDLE: a tick with CNT=0xFF sets CNT<=0x00 and goes to DELAY.
//   - DELAY (1 clk1): CNT reads 0x00. A CPU write to CNT stores wdata, cancels the reload and
//     the irq, and returns to IDLE. Otherwise go to RELOAD.
//   - RELOAD (1 clk1): CNT<=MOD and irq[n]=1 this cycle, then IDLE. A CNT write in this cycle is
//     ignored. A MOD write in this cycle is visible both in MOD and in the loaded CNT
//     (write-through).
//   - A tick during DELAY or RELOAD is dropped.
//  A CNT write in IDLE stores wdata. If a tick occurs in the same cycle, the write wins and no
//   increment occurs.
//  Reads: DIV returns div[DIV_W-1:DIV_W-8]. CNT/MOD/CTL return current register values.
//   Unmapped offsets and channels >= N_TIMERS read 0xFF, and writes to them are dropped.
//  Latency: register write is visible on rdata the next cycle. irq is asserted 2 clk1 after
//   the overflowing tick edge.
//  Channels are fully independent. Simultaneous overflows give simultaneous irq bits.
//  Mid-operation reset aborts DELAY/RELOAD with no irq.
// STRUCTURE
//  Shared package div_timer_pkg: address offset localparams (OFS_DIV, OFS_CNT, OFS_MOD,
//   OFS_CTL), CTL bit positions, reload FSM state encoding (2-bit).
//  Top level holds the divider, address decode, read mux and the tap-select per channel.
//  Sub-module timer_channel (one per channel, generate loop): inputs tap bit, wr_cnt/wr_mod/
//   wr_ctl, wdata; outputs cnt, mod, ctl, irq. Contains edge detector, counter and reload FSM.
// TESTING
//  1 Reset, ce=1 for 256 cycles, read addr 0 -> 0x01. Write addr 0 -> next read 0x00.
//  2 CTL0=0x05 (en, sel1=bit3), MOD0=0xF0, CNT0=0xFE. After 32 ce cycles CNT0 reads 0x00 for
//    one cycle, then 0xF0, with irq[0] pulsed exactly once, 2 cycles after the tick.
//  3 Overflow as in 2, write CNT0=0x33 during DELAY -> CNT0=0x33 and no irq.
//    Repeat writing during RELOAD -> CNT0=0xF0, irq asserted.
//  4 sel=1, run ce until div[3]=1, write addr 0 -> CNT0 +1 extra. Same for en 1->0 with
//    div[3]=1. No increment when div[3]=0.
//  5 N_TIMERS=2, DIV_W=20, CTL1 sel=0 (bit9): channels count at 1:64 rate ratio. A read of
//    addr 9 (channel 2) returns 0xFF.
//  6 Assert nreset during DELAY -> all regs 0, irq stays 0. Random wr/rd/ce soak vs
//    reference model, 100k cycles.

Source files
------------

// File: rtl/div_timer_pkg.sv
// Shared definitions for the divider/timer bank: register offsets, CTL bit
// layout and the per-channel overflow/reload state encoding.
package div_timer_pkg;

    // Register offset within a 4-byte channel window (addr[1:0]).
    // Offset 0 of window 0 is the divider; offset 0 of other windows is unmapped.
    localparam logic [1:0] OFS_DIV = 2'd0;
    localparam logic [1:0] OFS_CNT = 2'd1;
    localparam logic [1:0] OFS_MOD = 2'd2;
    localparam logic [1:0] OFS_CTL = 2'd3;

    // CTL layout: bit2 enable, bits1:0 tap select; upper bits are read-as-one.
    localparam int CTL_W      = 3;
    localparam int CTL_EN     = 2;
    localparam int CTL_SEL_HI = 1;
    localparam int CTL_SEL_LO = 0;

    // Overflow handling: IDLE counts, DELAY shows 0x00 for one cycle,
    // RELOAD is the cycle in which MOD is present in CNT and irq is high.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_RELOAD = 2'd2
    } reload_state_t;

endpackage

// File: rtl/timer_channel.sv
// One programmable timer channel: falling-edge detector on the selected
// divider tap, 8-bit counter, modulo register and overflow/reload FSM.
module timer_channel
    import div_timer_pkg::*;
(
    input  logic             clk1,
    input  logic             nreset,
    input  logic             tap_bit,
    input  logic             wr_cnt,
    input  logic             wr_mod,
    input  logic             wr_ctl,
    input  logic [7:0]       wdata,
    output logic [7:0]       cnt,
    output logic [7:0]       mod,
    output logic [CTL_W-1:0] ctl,
    output logic             irq
);

    logic [7:0]       cnt_reg;
    logic [7:0]       mod_reg;
    logic [CTL_W-1:0] ctl_reg;
    logic             t_q_reg;
    logic             irq_reg;
    reload_state_t    state_reg;

    logic t_now;
    logic tick;

    // Gating by enable happens before the edge detector, so clearing en while
    // the tap is high, a DIV clear or a sel change all look like a falling edge.
    assign t_now = ctl_reg[CTL_EN] & tap_bit;
    assign tick  = t_q_reg & ~t_now;

    // Delayed copy of the gated tap for falling-edge detection.
    always_ff @(posedge clk1) begin
        if (!nreset) begin
            t_q_reg <= 1'b0;
        end else begin
            t_q_reg <= t_now;
        end
    end

    // CPU-writable configuration registers.
    always_ff @(posedge clk1) begin
        if (!nreset) begin
            ctl_reg <= '0;
            mod_reg <= 8'h00;
        end else begin
            if (wr_ctl) begin
                ctl_reg <= wdata[CTL_W-1:0];
            end
            if (wr_mod) begin
                mod_reg <= wdata;
            end
        end
    end

    // Counter and overflow/reload sequencing; ticks outside IDLE are dropped.
    always_ff @(posedge clk1) begin
        if (!nreset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 8'h00;
            irq_reg   <= 1'b0;
        end else begin
            irq_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (wr_cnt) begin
                        cnt_reg <= wdata;
                    end else if (tick) begin
                        if (cnt_reg == 8'hFF) begin
                            cnt_reg   <= 8'h00;
                            state_reg <= ST_DELAY;
                        end else begin
                            cnt_reg <= cnt_reg + 8'd1;
                        end
                    end
                end
                ST_DELAY: begin
                    if (wr_cnt) begin
                        // CPU rewrite cancels both the reload and the interrupt.
                        cnt_reg   <= wdata;
                        state_reg <= ST_IDLE;
                    end else begin
                        // A MOD write landing now is forwarded into the load.
                        cnt_reg   <= wr_mod ? wdata : mod_reg;
                        irq_reg   <= 1'b1;
                        state_reg <= ST_RELOAD;
                    end
                end
                ST_RELOAD: begin
                    // CNT writes are ignored here; MOD writes pass through to CNT.
                    if (wr_mod) begin
                        cnt_reg <= wdata;
                    end
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign cnt = cnt_reg;
    assign mod = mod_reg;
    assign ctl = ctl_reg;
    assign irq = irq_reg;

endmodule

// File: rtl/div_timer_bank.sv
// Free-running system divider plus N_TIMERS programmable timer channels on a
// byte-wide register bus. Holds the divider, address decode, read mux and the
// per-channel divider tap selection.
module div_timer_bank
    import div_timer_pkg::*;
#(
    parameter int DIV_W    = 16,
    parameter int N_TIMERS = 1,
    parameter int TAP0     = 9,
    parameter int TAP1     = 3,
    parameter int TAP2     = 5,
    parameter int TAP3     = 7,
    parameter int APU_TAP  = 12
) (
    input  logic                clk1,
    input  logic                nreset,
    input  logic                ce,
    input  logic [3:0]          addr,
    input  logic [7:0]          wdata,
    input  logic                wr,
    input  logic                rd,
    output logic [7:0]          rdata,
    output logic [N_TIMERS-1:0] irq,
    output logic                div_tap
);

    logic [DIV_W-1:0] div_reg;
    logic [1:0]       ch_idx;
    logic [1:0]       ofs;
    logic             div_clr;

    logic [7:0]       cnt_arr [N_TIMERS];
    logic [7:0]       mod_arr [N_TIMERS];
    logic [CTL_W-1:0] ctl_arr [N_TIMERS];

    assign ch_idx  = addr[3:2];
    assign ofs     = addr[1:0];
    assign div_clr = wr && (addr == 4'd0);

    // System divider; a CPU write clears it and takes priority over ce.
    always_ff @(posedge clk1) begin
        if (!nreset) begin
            div_reg <= '0;
        end else if (div_clr) begin
            div_reg <= '0;
        end else if (ce) begin
            div_reg <= div_reg + DIV_W'(1);
        end
    end

    // Straight from the flop so the APU sequencer sees no decode glitches.
    assign div_tap = div_reg[APU_TAP];

    generate
        for (genvar gi = 0; gi < N_TIMERS; gi++) begin : g_ch
            logic tap_sel;
            logic wr_cnt;
            logic wr_mod;
            logic wr_ctl;

            assign wr_cnt = wr && (ch_idx == 2'(gi)) && (ofs == OFS_CNT);
            assign wr_mod = wr && (ch_idx == 2'(gi)) && (ofs == OFS_MOD);
            assign wr_ctl = wr && (ch_idx == 2'(gi)) && (ofs == OFS_CTL);

            // Divider bit driving this channel, chosen by CTL.sel.
            always_comb begin
                case (ctl_arr[gi][CTL_SEL_HI:CTL_SEL_LO])
                    2'd0:    tap_sel = div_reg[TAP0];
                    2'd1:    tap_sel = div_reg[TAP1];
                    2'd2:    tap_sel = div_reg[TAP2];
                    default: tap_sel = div_reg[TAP3];
                endcase
            end

            timer_channel u_ch (
                .clk1    (clk1),
                .nreset  (nreset),
                .tap_bit (tap_sel),
                .wr_cnt  (wr_cnt),
                .wr_mod  (wr_mod),
                .wr_ctl  (wr_ctl),
                .wdata   (wdata),
                .cnt     (cnt_arr[gi]),
                .mod     (mod_arr[gi]),
                .ctl     (ctl_arr[gi]),
                .irq     (irq[gi])
            );
        end
    endgenerate

    // Read mux: idle bus and unmapped locations return all ones.
    always_comb begin
        rdata = 8'hFF;
        if (rd) begin
            if (addr == 4'd0) begin
                rdata = div_reg[DIV_W-1 -: 8];
            end else begin
                for (int n = 0; n < N_TIMERS; n++) begin
                    if (ch_idx == 2'(n)) begin
                        case (ofs)
                            OFS_CNT: rdata = cnt_arr[n];
                            OFS_MOD: rdata = mod_arr[n];
                            OFS_CTL: rdata = {{(8-CTL_W){1'b1}}, ctl_arr[n]};
                            default: rdata = 8'hFF;
                        endcase
                    end
                end
            end
        end
    end

endmodule
